// File: rtl/song_sequencer_pkg.sv
// Shared constants for the song sequencer: FSM states, tempo codes, note field widths.
// Pure declarations, no logic.
package song_sequencer_pkg;

  localparam int OCT_W  = 3;
  localparam int NOTE_W = 3;
  localparam int LEN_W  = 3;

  localparam logic [1:0] MOD_HALF   = 2'b10;
  localparam logic [1:0] MOD_DOUBLE = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_PLAY,
    ST_GAP,
    ST_DONE
  } state_t;

endpackage

// File: rtl/song_sequencer_note_timer.sv
// Loadable down-counter; o_tc pulses on the last running, unpaused cycle of a count.
// Load has priority over counting; pause freezes the remaining count.
module note_timer #(
  parameter int W = 29
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_run,
  input  logic         i_pause,
  output logic         o_tc
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_run && !i_pause && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_tc = i_run && !i_pause && (r_cnt == W'(1));

endmodule

// File: rtl/song_sequencer.sv
// Walks the song ROM, timing each note (PLAY) and the silent articulation gap (GAP).
// All outputs registered from the next state; pause freezes timing, en low aborts to IDLE.
module song_sequencer
  import song_sequencer_pkg::*;
#(
  parameter int SONG_CNT_BITS  = 8,
  parameter int FULL_NOTE_BITS = 28,
  parameter int GAP_CYCLES     = 1_000_000
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic                      start,
  input  logic                      pause,
  input  logic [1:0]                mod,
  input  logic [SONG_CNT_BITS-1:0]  track,
  input  logic [FULL_NOTE_BITS-1:0] full_note,
  input  logic [OCT_W-1:0]          rom_octave,
  input  logic [NOTE_W-1:0]         rom_note,
  input  logic [LEN_W-1:0]          rom_length,
  output logic [SONG_CNT_BITS-1:0]  rom_addr,
  output logic [OCT_W-1:0]          goal_octave,
  output logic [NOTE_W-1:0]         goal_note,
  output logic [LEN_W-1:0]          goal_length,
  output logic                      sound_en,
  output logic                      note_start,
  output logic                      note_over,
  output logic                      song_done,
  output logic                      busy
);

  // One extra bit so half-time doubling of the full-note period cannot overflow.
  localparam int CW = FULL_NOTE_BITS + 1;
  localparam logic [CW-1:0] GAP_LOAD = CW'(GAP_CYCLES);

  state_t                     r_state, w_next;
  logic [SONG_CNT_BITS-1:0]   r_rom_addr, w_addr_next;
  logic [OCT_W-1:0]           r_goal_octave;
  logic [NOTE_W-1:0]          r_goal_note;
  logic [LEN_W-1:0]           r_goal_length;
  logic                       r_sound_en, r_note_start, r_note_over, r_song_done, r_busy;
  logic [CW-1:0]              w_base, w_scaled, w_dur, w_load_val;
  logic                       w_load, w_run, w_tc, w_last;

  assign w_base = {1'b0, full_note} >> rom_length;

  always_comb begin
    w_scaled = w_base;
    if (mod == MOD_HALF) begin
      w_scaled = w_base << 1;
    end else if (mod == MOD_DOUBLE) begin
      w_scaled = w_base >> 1;
    end
  end

  assign w_dur  = (w_scaled == '0) ? CW'(1) : w_scaled;
  assign w_run  = (r_state == ST_PLAY) || (r_state == ST_GAP);
  assign w_last = (r_rom_addr == track - 1'b1);

  note_timer #(.W(CW)) u_note_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .i_run      (w_run),
    .i_pause    (pause),
    .o_tc       (w_tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next      = r_state;
    w_load      = 1'b0;
    w_load_val  = w_dur;
    w_addr_next = r_rom_addr;
    unique case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_next = (track == '0) ? ST_DONE : ST_FETCH;
        end
      end
      ST_FETCH: begin
        w_load = 1'b1;
        w_next = ST_PLAY;
      end
      ST_PLAY: begin
        if (w_tc) begin
          w_load     = 1'b1;
          w_load_val = GAP_LOAD;
          w_next     = ST_GAP;
        end
      end
      ST_GAP: begin
        if (w_tc) begin
          if (w_last) begin
            w_next = ST_DONE;
          end else begin
            w_next      = ST_FETCH;
            w_addr_next = r_rom_addr + 1'b1;
          end
        end
      end
      ST_DONE: w_next = ST_DONE;
      default: w_next = ST_IDLE;
    endcase
    if (!en) begin
      w_next      = ST_IDLE;
      w_load      = 1'b0;
      w_addr_next = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rom_addr    <= '0;
      r_goal_octave <= '0;
      r_goal_note   <= '0;
      r_goal_length <= '0;
      r_sound_en    <= 1'b0;
      r_note_start  <= 1'b0;
      r_note_over   <= 1'b0;
      r_song_done   <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_rom_addr <= w_addr_next;
      if (w_next == ST_IDLE) begin
        r_goal_octave <= '0;
        r_goal_note   <= '0;
        r_goal_length <= '0;
      end else if (r_state == ST_FETCH) begin
        r_goal_octave <= rom_octave;
        r_goal_note   <= rom_note;
        r_goal_length <= rom_length;
      end
      r_sound_en   <= (w_next == ST_PLAY) && !(pause && (r_state == ST_PLAY));
      r_note_start <= (r_state == ST_FETCH) && (w_next == ST_PLAY);
      r_note_over  <= (r_state == ST_PLAY) && (w_next == ST_GAP);
      r_song_done  <= (w_next == ST_DONE);
      r_busy       <= (w_next == ST_FETCH) || (w_next == ST_PLAY) || (w_next == ST_GAP);
    end
  end

  assign rom_addr    = r_rom_addr;
  assign goal_octave = r_goal_octave;
  assign goal_note   = r_goal_note;
  assign goal_length = r_goal_length;
  assign sound_en    = r_sound_en;
  assign note_start  = r_note_start;
  assign note_over   = r_note_over;
  assign song_done   = r_song_done;
  assign busy        = r_busy;

endmodule

// File: tb/tb_song_sequencer.sv
// Bench for song_sequencer: phase-level song model plus directed scenarios with literal timings.
module tb_song_sequencer;

  localparam int GAP = 4;
  localparam int LEN = 2;

  logic        clk = 1'b0;
  logic        rst_n, en, start, pause;
  logic [1:0]  mod;
  logic [7:0]  track;
  logic [27:0] full_note;
  logic [2:0]  rom_octave, rom_note, rom_length;
  logic [7:0]  rom_addr;
  logic [2:0]  goal_octave, goal_note, goal_length;
  logic        sound_en, note_start, note_over, song_done, busy;

  always #5 clk = ~clk;

  song_sequencer #(.SONG_CNT_BITS(8), .FULL_NOTE_BITS(28), .GAP_CYCLES(GAP)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .start(start), .pause(pause), .mod(mod),
    .track(track), .full_note(full_note),
    .rom_octave(rom_octave), .rom_note(rom_note), .rom_length(rom_length),
    .rom_addr(rom_addr), .goal_octave(goal_octave), .goal_note(goal_note),
    .goal_length(goal_length), .sound_en(sound_en), .note_start(note_start),
    .note_over(note_over), .song_done(song_done), .busy(busy)
  );

  // Song ROM contents: entry i -> octave i+1, note 7-i, fixed length code.
  assign rom_octave = rom_addr[2:0] + 3'd1;
  assign rom_note   = 3'd7 - rom_addr[2:0];
  assign rom_length = 3'(LEN);

  wire [21:0] dut_vec = {rom_addr, goal_octave, goal_note, goal_length,
                         sound_en, note_start, note_over, song_done, busy};

  int          n_chk = 0;
  int          n_fail = 0;
  logic [21:0] exp_q[$];
  int          pop_idx = 0;
  int          snd_tot = 0;
  int          ns_q[$];
  int          ov_q[$];
  int          dn_q[$];
  int          pz[0:255];
  int          mz[0:255];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  function automatic int model_dur(input int fn, input int len, input int m);
    int d;
    d = fn / (1 << len);
    if (m == 2) d = d * 2;
    else if (m == 3) d = d / 2;
    if (d < 1) d = 1;
    return d;
  endfunction

  function automatic logic [8:0] goal_of(input int i);
    logic [2:0] o, n;
    o = 3'(i + 1);
    n = 3'(7 - i);
    return {o, n, 3'(LEN)};
  endfunction

  function automatic logic [21:0] pk(input int addr, input logic [8:0] g, input logic snd,
                                     input logic ns, input logic no, input logic dn, input logic bs);
    return {8'(addr), g, snd, ns, no, dn, bs};
  endfunction

  function automatic int nth_rel(input int q[$], input int base, input int k);
    int seen;
    seen = 0;
    foreach (q[j]) begin
      if (q[j] >= base) begin
        if (seen == k) return q[j] - base;
        seen++;
      end
    end
    return -1;
  endfunction

  function automatic int cnt_rel(input int q[$], input int base);
    int c;
    c = 0;
    foreach (q[j]) if (q[j] >= base) c++;
    return c;
  endfunction

  // Compare process: one packed comparison per expected cycle, plus event logging.
  initial begin
    logic [21:0] e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check($sformatf("cyc%0d", pop_idx), 32'(dut_vec), 32'(e));
        if (note_start) ns_q.push_back(pop_idx);
        if (note_over)  ov_q.push_back(pop_idx);
        if (song_done)  dn_q.push_back(pop_idx);
        if (sound_en)   snd_tot++;
        pop_idx++;
      end
    end
  end

  // Plays one song: start pulse, per-cycle pause/mod/start tables, en dropped in cycle n-1.
  // Expected outputs for relative cycles 0..n are built phase by phase from the song rules.
  task automatic run_song(output int base, output int snd, input int trk, input int fn,
                          input int m0, input int m1, input int p_from, input int p_len,
                          input int glitch_at, input int n);
    logic [21:0] ev[0:255];
    logic [8:0]  last_goal;
    int          r, cnt, dur, last_addr, snd0;
    bit          prevp, first;
    for (int k = 0; k <= n; k++) begin
      pz[k] = (k >= p_from && k < p_from + p_len) ? 1 : 0;
      mz[k] = (k == 0) ? m0 : m1;
      ev[k] = '0;
    end
    r = 0;
    last_goal = '0;
    last_addr = 0;
    for (int i = 0; i < trk && r <= n; i++) begin
      ev[r] = pk(i, last_goal, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      dur = model_dur(fn, LEN, mz[r]);
      r++;
      cnt = 0; first = 1'b1; prevp = 1'b0;
      while (cnt < dur && r <= n) begin
        ev[r] = pk(i, goal_of(i), !prevp, first, 1'b0, 1'b0, 1'b1);
        first = 1'b0;
        if (pz[r] == 0) cnt++;
        prevp = (pz[r] != 0);
        r++;
      end
      cnt = 0; first = 1'b1;
      while (cnt < GAP && r <= n) begin
        ev[r] = pk(i, goal_of(i), 1'b0, 1'b0, first, 1'b0, 1'b1);
        first = 1'b0;
        if (pz[r] == 0) cnt++;
        r++;
      end
      last_goal = goal_of(i);
      last_addr = i;
    end
    while (r <= n) begin
      ev[r] = pk(last_addr, last_goal, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      r++;
    end
    ev[n] = '0;

    track = 8'(trk);
    full_note = 28'(fn);
    mod = 2'(mz[0]);
    pause = 1'b0;
    en = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    base = pop_idx;
    snd0 = snd_tot;
    for (int k = 0; k <= n; k++) exp_q.push_back(ev[k]);
    for (int k = 0; k < n; k++) begin
      pause = (pz[k] != 0);
      mod   = 2'(mz[k]);
      en    = (k != n - 1);
      start = (k == glitch_at);
      @(posedge clk); #1;
    end
    pause = 1'b0;
    start = 1'b0;
    en = 1'b1;
    @(posedge clk); #1;
    snd = snd_tot - snd0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, pending=%0d", exp_q.size());
    $fatal(1, "watchdog");
  end

  initial begin
    int b, s;
    rst_n = 1'b0; en = 1'b0; start = 1'b0; pause = 1'b0; mod = 2'b00;
    track = 8'd0; full_note = 28'd64;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", 32'(dut_vec), 32'h0);
    rst_n = 1'b1;
    en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("idle_no_start", 32'(dut_vec), 32'h0);

    // Three notes at normal tempo, stray start mid-note.
    run_song(b, s, 3, 64, 0, 0, 999, 0, 5, 66);
    check("A_ns0", nth_rel(ns_q, b, 0), 1);
    check("A_ns1", nth_rel(ns_q, b, 1), 22);
    check("A_ns2", nth_rel(ns_q, b, 2), 43);
    check("A_ov0", nth_rel(ov_q, b, 0), 17);
    check("A_done", nth_rel(dn_q, b, 0), 63);
    check("A_snd", s, 48);

    // Half time, mod changed back mid-note.
    run_song(b, s, 1, 64, 2, 0, 999, 0, -1, 40);
    check("half_snd", s, 32);
    check("half_done", nth_rel(dn_q, b, 0), 37);

    run_song(b, s, 1, 64, 3, 3, 999, 0, -1, 16);
    check("dbl_snd", s, 8);

    run_song(b, s, 1, 1, 3, 3, 999, 0, -1, 8);
    check("clamp_snd", s, 1);
    check("clamp_ov", nth_rel(ov_q, b, 0), 2);

    // Ten paused cycles inside note 0.
    run_song(b, s, 1, 64, 0, 0, 5, 10, -1, 34);
    check("pause_win", nth_rel(ov_q, b, 0) - nth_rel(ns_q, b, 0), 26);
    check("pause_snd", s, 16);

    // en dropped in the second GAP cycle of note 1.
    run_song(b, s, 3, 64, 0, 0, 999, 0, -1, 40);
    check("abort_ov", cnt_rel(ov_q, b), 2);
    check("abort_done", cnt_rel(dn_q, b), 0);

    run_song(b, s, 2, 64, 0, 0, 999, 0, -1, 45);
    check("replay_ns1", nth_rel(ns_q, b, 1), 22);
    check("replay_done", nth_rel(dn_q, b, 0), 42);

    run_song(b, s, 0, 64, 0, 0, 999, 0, -1, 3);
    check("t0_done", nth_rel(dn_q, b, 0), 0);
    check("t0_ns", cnt_rel(ns_q, b), 0);

    // Asynchronous reset in the middle of PLAY.
    track = 8'd3; full_note = 28'd64; mod = 2'b00; en = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("prerst_busy", 32'(busy), 32'h1);
    check("prerst_snd", 32'(sound_en), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_async", 32'(dut_vec), 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_needs_start", 32'(dut_vec), 32'h0);

    run_song(b, s, 1, 64, 3, 3, 999, 0, -1, 16);
    check("post_rst_snd", s, 8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
